pleiads_dl_ctrl: RTL and testbench
==================================

# pleiads_dl_ctrl

Download controller between the HPS ioctl stream and the Pleiads core's ROM load port. It registers each downloaded byte and forwards it as a single-cycle write, decodes the target ROM region, and counts bytes. After the download ends it checks length (and optionally an additive checksum), then holds the core in reset for a programmable number of cycles before release. It replaces the direct `ioctl_* → dn_*` wiring and the `ioctl_download` term in the core reset OR.

## Interface
- `EXP_LEN`, default 16'h6200: expected total byte count (16K program, 4K bg chars, 4K fg chars, 512 B PROMs).
- `HOLD_CYCLES`, default 1024: core-reset stretch after download end; legal range 1..65535.
- `EXP_SUM`, default 8'h00: expected modulo-256 byte sum (used only with `DL_CHECKSUM_EN`).
- `clk`  in  1  system clock (`clk_sys` domain).
- `reset_n`  in  1  asynchronous, active-low reset.
- `ioctl_download`  in  1  download window, level.
- `ioctl_wr`  in  1  byte strobe, one cycle per byte.
- `ioctl_addr`  in  25  byte address.
- `ioctl_dout`  in  8  byte data.
- `dn_addr`  out  16  registered write address (`ioctl_addr[15:0]`).
- `dn_data`  out  8  registered write data.
- `dn_wr`  out  1  one-cycle write strobe.
- `dn_region`  out  4  one-hot region of the current `dn_wr`: [0] prog, [1] bg, [2] fg, [3] prom.
- `core_reset`  out  1  active-high reset to the core.
- `dl_ok`  out  1  last download passed its checks.
- `dl_err`  out  1  last download failed (length, overflow or checksum).

## Operation
- FSM states: BOOT, LOAD, CHECK, HOLD, RUN.
- BOOT (reset state):
  - `core_reset`=1.
  - `ioctl_download` rise → LOAD.
- LOAD:
  - On entry, clear the byte count, running sum and overflow flag, and clear `dl_ok`/`dl_err`.
  - Each `ioctl_wr` pulse:
    - register addr and data to `dn_*` and pulse `dn_wr`;
    - count += 1, saturating at 16'hFFFF;
    - sum += data, modulo 256.
  - Region decode on `ioctl_addr`:
    - 0x0000–0x3FFF prog;
    - 0x4000–0x4FFF bg;
    - 0x5000–0x5FFF fg;
    - 0x6000–0x61FF prom.
  - Any address ≥ 0x6200, including any nonzero `ioctl_addr[24:16]`:
    - no `dn_wr` is issued;
    - the overflow flag is set;
    - the byte is still counted and summed.
  - `ioctl_download` fall → CHECK.
- CHECK, one cycle:
  - pass = (count == `EXP_LEN`) && !overflow [&& sum == `EXP_SUM`].
  - Set `dl_ok`=pass and `dl_err`=!pass.
  - Load the hold counter with `HOLD_CYCLES`-1, then → HOLD.
- HOLD:
  - Decrement the hold counter each cycle.
  - At 0: → RUN if pass; otherwise → BOOT, so `core_reset` stays asserted.
- RUN:
  - `core_reset`=0.
  - `ioctl_download` rise → LOAD.
- `core_reset`=1 in every state except RUN.
- From HOLD, an `ioctl_download` rise aborts the hold and goes to LOAD (new download).

## Timing
- Reset values:
  - `dn_addr`=0, `dn_data`=0, `dn_wr`=0, `dn_region`=0;
  - `core_reset`=1, `dl_ok`=0, `dl_err`=0;
  - state BOOT.
- Write latency is 1 cycle, `ioctl_wr` → `dn_wr`. Back-to-back `ioctl_wr` on consecutive cycles is supported. There is no backpressure.
- `dn_region` is valid only while `dn_wr`=1; it is 0 otherwise.
- `ioctl_wr` in the same cycle as the `ioctl_download` fall:
  - the byte is written and counted;
  - CHECK sees the updated count next cycle.
- `ioctl_wr` outside LOAD is ignored: no write, no count.
- Release timing: `core_reset` deasserts exactly `HOLD_CYCLES`+1 cycles after the first cycle with `ioctl_download`=0 (1 CHECK + `HOLD_CYCLES` HOLD).
- `reset_n` low at any time: all outputs take their reset values immediately (async). Resume from BOOT on the first clock after deassertion.

## Configuration
- `PLEIADS_DL_CHECKSUM_EN` defined:
  - the sum register and the `EXP_SUM` comparison are compiled in;
  - a sum mismatch contributes to `dl_err`.
- Not defined:
  - no sum logic;
  - pass = length and overflow checks only;
  - `EXP_SUM` is unused.

## Structure
- Package `pleiads_dl_pkg` holds:
  - region base/limit constants (`PROG_BASE`, `BG_BASE`, `FG_BASE`, `PROM_BASE`, `ROM_END`);
  - the region one-hot typedef;
  - the FSM state enum.
- One sub-module, `pleiads_dl_region`: purely combinational, address in, one-hot region plus out-of-range out. It is shared with any future SDRAM-backed loader.
- FSM, counters and output registers live in `pleiads_dl_ctrl`.

## Test plan
- Reset: hold `reset_n`=0 with random inputs → `core_reset`=1, `dn_wr`=0, `dl_ok`=`dl_err`=0. After release, state BOOT and no writes.
- Full download:
  - Stimulus: 0x6200 bytes, value=addr[7:0], back-to-back `ioctl_wr`.
  - Response: `dn_wr` count = 0x6200, each one cycle late with matching addr/data. Regions switch at 0x4000/0x5000/0x6000. `dl_ok`=1. `core_reset` falls exactly `HOLD_CYCLES`+1 cycles after the download fall.
- Short download of 0x6100 bytes → `dl_err`=1, `dl_ok`=0, `core_reset` remains 1 (state BOOT).
- Overflow:
  - Stimulus: a full image plus one byte at 0x6200.
  - Response: no `dn_wr` for that byte, `dl_err`=1.
- With `PLEIADS_DL_CHECKSUM_EN`: a full image with one corrupted byte → `dl_err`=1. Without the macro, the same image → `dl_ok`=1.
- Edge cases:
  - Restart: a new `ioctl_download` rise during HOLD → goes to LOAD, counters cleared; a second good image → `dl_ok`=1.
  - Same-cycle strobe: last `ioctl_wr` coincident with the download fall → that byte is counted, `dl_ok`=1.

Source files
------------

// File: rtl/pleiads_dl_pkg.sv
// Shared constants and types for the Pleiads ROM download path.
// Region map is common to the ioctl loader and any SDRAM-backed loader.
package pleiads_dl_pkg;

    localparam logic [15:0] PROG_BASE = 16'h0000;
    localparam logic [15:0] BG_BASE   = 16'h4000;
    localparam logic [15:0] FG_BASE   = 16'h5000;
    localparam logic [15:0] PROM_BASE = 16'h6000;
    localparam logic [15:0] ROM_END   = 16'h6200;

    typedef logic [3:0] region_t;

    localparam region_t RGN_NONE = 4'b0000;
    localparam region_t RGN_PROG = 4'b0001;
    localparam region_t RGN_BG   = 4'b0010;
    localparam region_t RGN_FG   = 4'b0100;
    localparam region_t RGN_PROM = 4'b1000;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_LOAD,
        ST_CHECK,
        ST_HOLD,
        ST_RUN
    } state_t;

endpackage

// File: rtl/pleiads_dl_region.sv
// Combinational ROM region decoder: byte address to one-hot region.
// Anything past ROM_END, or with upper address bits set, is out of range.
module pleiads_dl_region
    import pleiads_dl_pkg::*;
(
    input  logic [24:0] addr,
    output logic [3:0]  region,
    output logic        out_of_range
);

    logic [15:0] lo;
    logic        hi_zero;

    assign lo      = addr[15:0];
    assign hi_zero = (addr[24:16] == 9'd0);

    always_comb begin
        region       = RGN_NONE;
        out_of_range = 1'b0;
        if (!hi_zero || lo >= ROM_END) begin
            out_of_range = 1'b1;
        end else if (lo >= PROM_BASE) begin
            region = RGN_PROM;
        end else if (lo >= FG_BASE) begin
            region = RGN_FG;
        end else if (lo >= BG_BASE) begin
            region = RGN_BG;
        end else if ((lo - PROG_BASE) < (BG_BASE - PROG_BASE)) begin
            region = RGN_PROG;
        end
    end

endmodule

// File: rtl/pleiads_dl_ctrl.sv
// ioctl download controller: forwards bytes, checks the image, stretches core reset.
// Optional PLEIADS_DL_CHECKSUM_EN adds a modulo-256 byte-sum check.
module pleiads_dl_ctrl
    import pleiads_dl_pkg::*;
#(
    parameter logic [15:0] EXP_LEN     = 16'h6200,
    parameter int unsigned HOLD_CYCLES = 1024,
    parameter logic [7:0]  EXP_SUM     = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic [3:0]  dn_region,
    output logic        core_reset,
    output logic        dl_ok,
    output logic        dl_err
);

    localparam logic [15:0] HOLD_INIT = 16'(HOLD_CYCLES - 1);

    state_t      state;
    state_t      state_n;
    logic        dl_q;
    logic        rise;
    logic        accept;
    logic        enter_load;
    logic        pass;
    logic        oor;
    region_t     region;
    logic [15:0] count;
    logic [15:0] hold_cnt;
    logic        ovf;

    pleiads_dl_region u_region (
        .addr         (ioctl_addr),
        .region       (region),
        .out_of_range (oor)
    );

    assign rise       = ioctl_download & ~dl_q;
    assign accept     = (state == ST_LOAD) & ioctl_wr;
    assign enter_load = (state_n == ST_LOAD) & (state != ST_LOAD);

`ifdef PLEIADS_DL_CHECKSUM_EN
    logic [7:0] sum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum <= 8'd0;
        end else if (enter_load) begin
            sum <= 8'd0;
        end else if (accept) begin
            sum <= sum + ioctl_dout;
        end
    end

    assign pass = (count == EXP_LEN) & ~ovf & (sum == EXP_SUM);
`else
    logic unused_sum;

    assign unused_sum = ^EXP_SUM;
    assign pass       = (count == EXP_LEN) & ~ovf;
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            ST_BOOT: begin
                if (rise) state_n = ST_LOAD;
            end
            ST_LOAD: begin
                if (!ioctl_download) state_n = ST_CHECK;
            end
            ST_CHECK: begin
                state_n = ST_HOLD;
            end
            ST_HOLD: begin
                if (rise) begin
                    state_n = ST_LOAD;
                end else if (hold_cnt == 16'd0) begin
                    state_n = dl_ok ? ST_RUN : ST_BOOT;
                end
            end
            ST_RUN: begin
                if (rise) state_n = ST_LOAD;
            end
            default: state_n = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_BOOT;
            dl_q       <= 1'b0;
            core_reset <= 1'b1;
        end else begin
            state      <= state_n;
            dl_q       <= ioctl_download;
            core_reset <= (state_n != ST_RUN);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= 16'd0;
            ovf   <= 1'b0;
        end else if (enter_load) begin
            count <= 16'd0;
            ovf   <= 1'b0;
        end else if (accept) begin
            if (count != 16'hFFFF) count <= count + 16'd1;
            if (oor) ovf <= 1'b1;
        end
    end

    // Out-of-range bytes are counted but never reach the core.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dn_addr   <= 16'd0;
            dn_data   <= 8'd0;
            dn_wr     <= 1'b0;
            dn_region <= RGN_NONE;
        end else begin
            dn_wr     <= accept & ~oor;
            dn_region <= (accept & ~oor) ? region : RGN_NONE;
            if (accept && !oor) begin
                dn_addr <= ioctl_addr[15:0];
                dn_data <= ioctl_dout;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dl_ok    <= 1'b0;
            dl_err   <= 1'b0;
            hold_cnt <= 16'd0;
        end else if (enter_load) begin
            dl_ok  <= 1'b0;
            dl_err <= 1'b0;
        end else if (state == ST_CHECK) begin
            dl_ok    <= pass;
            dl_err   <= ~pass;
            hold_cnt <= HOLD_INIT;
        end else if (state == ST_HOLD && hold_cnt != 16'd0) begin
            hold_cnt <= hold_cnt - 16'd1;
        end
    end

endmodule

// File: tb/tb_pleiads_dl_ctrl.sv
// Directed bench for pleiads_dl_ctrl with a compact 32-byte image
// spread over all four regions and their boundaries.
module tb_pleiads_dl_ctrl;

    localparam int H = 20;
    localparam logic [15:0] TB_LEN = 16'd32;
    localparam logic [7:0]  TB_SUM = 8'hF0;

    logic        clk;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic [3:0]  dn_region;
    logic        core_reset;
    logic        dl_ok;
    logic        dl_err;

    int checks = 0;
    int errors = 0;

    logic [15:0] img_addr [32];
    logic [24:0] qa [$];
    logic [7:0]  qd [$];

    pleiads_dl_ctrl #(
        .EXP_LEN     (TB_LEN),
        .HOLD_CYCLES (H),
        .EXP_SUM     (TB_SUM)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_wr          (dn_wr),
        .dn_region      (dn_region),
        .core_reset     (core_reset),
        .dl_ok          (dl_ok),
        .dl_err         (dl_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_region(input logic [24:0] a);
        if (a[24:16] != 9'd0 || a[15:0] >= 16'h6200) return 4'b0000;
        if (a[15:0] >= 16'h6000) return 4'b1000;
        if (a[15:0] >= 16'h5000) return 4'b0100;
        if (a[15:0] >= 16'h4000) return 4'b0010;
        return 4'b0001;
    endfunction

    task automatic chk_byte(input int j);
        logic [3:0] r;
        r = exp_region(qa[j]);
        if (r != 4'b0000) begin
            chk("dn_wr", 32'(dn_wr), 32'd1);
            chk("dn_addr", 32'(dn_addr), 32'(qa[j][15:0]));
            chk("dn_data", 32'(dn_data), 32'(qd[j]));
            chk("dn_region", 32'(dn_region), 32'(r));
        end else begin
            chk("dn_wr_oor", 32'(dn_wr), 32'd0);
            chk("dn_region_oor", 32'(dn_region), 32'd0);
        end
    endtask

    task automatic build_good();
        qa.delete();
        qd.delete();
        for (int i = 0; i < 32; i++) begin
            qa.push_back({9'd0, img_addr[i]});
            qd.push_back(8'h40 + 8'(i));
        end
    endtask

    // Called at a negedge. Returns the index of the current negedge
    // relative to the first cycle with ioctl_download low.
    task automatic send_img(input bit fall_last, output int idx);
        ioctl_download = 1'b1;
        ioctl_wr = 1'b0;
        @(negedge clk);
        chk("load_ok_clr", 32'(dl_ok), 32'd0);
        chk("load_err_clr", 32'(dl_err), 32'd0);
        chk("load_core_rst", 32'(core_reset), 32'd1);
        for (int i = 0; i < qa.size(); i++) begin
            if (i == 0) chk("first_no_wr", 32'(dn_wr), 32'd0);
            else chk_byte(i - 1);
            ioctl_wr = 1'b1;
            ioctl_addr = qa[i];
            ioctl_dout = qd[i];
            if (fall_last && i == qa.size() - 1) ioctl_download = 1'b0;
            @(negedge clk);
        end
        chk_byte(qa.size() - 1);
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        idx = fall_last ? 1 : 0;
    endtask

    task automatic wait_release(input int idx, input bit pass);
        repeat (2 - idx) @(negedge clk);
        chk("dl_ok", 32'(dl_ok), 32'(pass));
        chk("dl_err", 32'(dl_err), 32'(!pass));
        repeat (H - 1) @(negedge clk);
        chk("rst_before", 32'(core_reset), 32'd1);
        @(negedge clk);
        chk("rst_release", 32'(core_reset), 32'(!pass));
        repeat (4) @(negedge clk);
        chk("rst_settled", 32'(core_reset), 32'(!pass));
    endtask

    initial begin
        int idx;
        img_addr = '{16'h0000, 16'h0001, 16'h0100, 16'h1000,
                     16'h2000, 16'h3000, 16'h3FFE, 16'h3FFF,
                     16'h4000, 16'h4001, 16'h4100, 16'h4800,
                     16'h4A00, 16'h4F00, 16'h4FFE, 16'h4FFF,
                     16'h5000, 16'h5001, 16'h5100, 16'h5800,
                     16'h5A00, 16'h5F00, 16'h5FFE, 16'h5FFF,
                     16'h6000, 16'h6001, 16'h6080, 16'h6100,
                     16'h6180, 16'h61F0, 16'h61FE, 16'h61FF};

        reset_n = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ioctl_download = 1'($urandom);
            ioctl_wr = 1'($urandom);
            ioctl_addr = 25'($urandom);
            ioctl_dout = 8'($urandom);
        end
        @(negedge clk);
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_dn_wr", 32'(dn_wr), 32'd0);
        chk("rst_dl_ok", 32'(dl_ok), 32'd0);
        chk("rst_dl_err", 32'(dl_err), 32'd0);
        chk("rst_dn_addr", 32'(dn_addr), 32'd0);
        chk("rst_dn_region", 32'(dn_region), 32'd0);

        ioctl_download = 1'b0;
        ioctl_wr = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        ioctl_wr = 1'b1;
        ioctl_addr = 25'h0000100;
        ioctl_dout = 8'h5A;
        @(negedge clk);
        ioctl_wr = 1'b0;
        chk("boot_wr_ignored", 32'(dn_wr), 32'd0);
        chk("boot_core_reset", 32'(core_reset), 32'd1);
        @(negedge clk);

        // Good image; last strobe coincides with the download fall.
        build_good();
        send_img(1'b1, idx);
        wait_release(idx, 1'b1);

        ioctl_wr = 1'b1;
        ioctl_addr = 25'h0000010;
        @(negedge clk);
        ioctl_wr = 1'b0;
        chk("run_wr_ignored", 32'(dn_wr), 32'd0);
        chk("run_core_reset", 32'(core_reset), 32'd0);

        // Short image: one byte missing.
        build_good();
        void'(qa.pop_back());
        void'(qd.pop_back());
        send_img(1'b0, idx);
        wait_release(idx, 1'b0);

        // Overflow: 0x6200 and a high-bank address replace two bytes.
        build_good();
        qa[30] = 25'h0006200;
        qa[31] = 25'h0010005;
        send_img(1'b0, idx);
        wait_release(idx, 1'b0);

        // Corrupted byte: only a checksum build rejects it.
        build_good();
        qd[5] = qd[5] + 8'd1;
        send_img(1'b0, idx);
`ifdef PLEIADS_DL_CHECKSUM_EN
        wait_release(idx, 1'b0);
`else
        wait_release(idx, 1'b1);
`endif

        // Restart a download while the reset stretch is running.
        build_good();
        send_img(1'b0, idx);
        repeat (2) @(negedge clk);
        chk("pre_restart_ok", 32'(dl_ok), 32'd1);
        repeat (5) @(negedge clk);
        chk("hold_core_reset", 32'(core_reset), 32'd1);
        send_img(1'b0, idx);
        wait_release(idx, 1'b1);

        // Asynchronous reset from RUN, away from any clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_core_reset", 32'(core_reset), 32'd1);
        chk("async_dl_ok", 32'(dl_ok), 32'd0);
        chk("async_dn_addr", 32'(dn_addr), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_boot", 32'(core_reset), 32'd1);
        chk("post_rst_no_wr", 32'(dn_wr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
